// File: rtl/instr_fetch_queue_pkg.sv
// Shared CPU parameters: datapath widths and the NOP encoding used by the
// fetch queue and the program memory.
package instr_fetch_queue_pkg;

    localparam int unsigned CPU_WIDTH     = 32;
    localparam int unsigned CPU_ADD_WIDTH = 8;

    // addi x0, x0, 0
    localparam logic [CPU_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

endpackage : instr_fetch_queue_pkg

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a synchronous flush; simultaneous push and pop is allowed when full.
// Storage is not reset: occupancy alone decides which entries are meaningful.
module sync_fifo #(
    parameter  int unsigned WIDTH = 40,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty,
    output logic             o_full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty && !i_flush;
    assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

    // Pointers and occupancy; flush returns everything to the empty state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            if (w_do_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_tail] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_head];
    assign o_count = r_count;

endmodule : sync_fifo

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: sequences the fetch PC, handles redirects and buffers
// {pc, instruction} pairs for the fetch stage.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter  int unsigned WIDTH     = CPU_WIDTH,
    parameter  int unsigned ADD_WIDTH = CPU_ADD_WIDTH,
    parameter  int unsigned DEPTH     = 4,
    localparam int unsigned CNT_W     = $clog2(DEPTH) + 1,
    localparam int unsigned ENTRY_W   = WIDTH + ADD_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [ADD_WIDTH-1:0] mem_add,
    input  logic [WIDTH-1:0]     mem_instruction,
    input  logic                 redirect_valid,
    input  logic [ADD_WIDTH-1:0] redirect_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_instr,
    output logic [ADD_WIDTH-1:0] out_pc,
    output logic [CNT_W-1:0]     count
);

    logic [ADD_WIDTH-1:0] r_fetch_pc;
    logic [ENTRY_W-1:0]   w_rdata;
    logic [CNT_W-1:0]     w_count;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;

    assign w_pop  = !w_empty && out_ready;
    assign w_push = !redirect_valid && (!w_full || w_pop);

    // Fetch PC: redirect wins, otherwise advance only when the fetched word was queued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + ADD_WIDTH'(1);
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({r_fetch_pc, mem_instruction}),
        .o_rdata (w_rdata),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // Empty queue presents a NOP at address 0 so unwritten storage never leaks out
    assign mem_add   = r_fetch_pc;
    assign out_valid = !w_empty;
    assign count     = w_count;
    assign out_instr = w_empty ? WIDTH'(NOP_INSTR) : w_rdata[WIDTH-1:0];
    assign out_pc    = w_empty ? '0 : w_rdata[ENTRY_W-1:WIDTH];

endmodule : instr_fetch_queue

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a spec-level scoreboard of queued fetch addresses.
module tb_instr_fetch_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  mem_add;
    logic [31:0] mem_instruction;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [7:0]  out_pc;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_pc;
    logic [7:0] m_q[$];

    always #5 clk = ~clk;

    // Program memory: word n holds n+100
    assign mem_instruction = 32'(mem_add) + 32'd100;

    instr_fetch_queue #(.WIDTH(32), .ADD_WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_add         (mem_add),
        .mem_instruction (mem_instruction),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .count           (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("valid", 32'(out_valid), 32'(m_q.size() > 0));
        chk("count", 32'(count), 32'(m_q.size()));
        chk("mem_add", 32'(mem_add), 32'(m_pc));
        if (m_q.size() > 0) begin
            chk("head_pc", 32'(out_pc), 32'(m_q[0]));
            chk("head_instr", out_instr, 32'(m_q[0]) + 32'd100);
        end else begin
            chk("empty_pc", 32'(out_pc), 32'h0);
            chk("empty_instr", out_instr, 32'h0000_0013);
        end
    endtask

    // One rising edge: update the scoreboard from the driven inputs, then check at the falling edge
    task automatic tick();
        @(posedge clk);
        if (redirect_valid) begin
            m_q.delete();
            m_pc = redirect_pc;
        end else begin
            if (m_q.size() > 0 && out_ready) begin
                void'(m_q.pop_front());
            end
            if (m_q.size() < DEPTH) begin
                m_q.push_back(m_pc);
                m_pc = m_pc + 8'd1;
            end
        end
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_q.delete();
        m_pc = 8'h00;
        #2;
        check_model();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        m_pc = 8'h00;
        // Reset values
        do_reset();

        // Streaming with out_ready high: one-cycle latency, consecutive addresses
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k < 5) begin
                chk("stream_pc", 32'(out_pc), 32'(k));
                chk("stream_instr", out_instr, 32'(100 + k));
            end
        end

        // Back-pressure saturates the queue and freezes the fetch PC
        out_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 8; k++) tick();
        chk("full_count", 32'(count), 32'd4);
        chk("full_mem_add", 32'(mem_add), 32'd4);
        chk("full_head", 32'(out_pc), 32'd0);

        // One accept while full: push and pop together
        out_ready = 1'b1;
        tick();
        chk("fullpop_count", 32'(count), 32'd4);
        chk("fullpop_pc", 32'(out_pc), 32'd1);
        out_ready = 1'b0;
        tick();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) tick();

        // Redirect with 3 entries queued and a concurrent handshake
        out_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 3; k++) tick();
        chk("pre_redir_count", 32'(count), 32'd3);
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 8'h40;
        tick();
        chk("redir_count", 32'(count), 32'd0);
        chk("redir_valid", 32'(out_valid), 32'd0);
        redirect_valid = 1'b0;
        tick();
        chk("redir_target_pc", 32'(out_pc), 32'h40);
        chk("redir_target_valid", 32'(out_valid), 32'd1);

        // Back-to-back redirects: only the last target survives
        redirect_valid = 1'b1;
        redirect_pc = 8'h10;
        tick();
        redirect_pc = 8'h20;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("b2b_pc", 32'(out_pc), 32'h20);

        // Fetch PC wrap-around
        redirect_valid = 1'b1;
        redirect_pc = 8'hFE;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("wrap_pc0", 32'(out_pc), 32'hFE);
        tick();
        chk("wrap_pc1", 32'(out_pc), 32'hFF);
        tick();
        chk("wrap_pc2", 32'(out_pc), 32'h00);
        tick();
        chk("wrap_pc3", 32'(out_pc), 32'h01);

        // Asynchronous reset between edges with 2 entries queued
        out_ready = 1'b0;
        do_reset();
        tick();
        tick();
        chk("pre_async_count", 32'(count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_count", 32'(count), 32'd0);
        m_q.delete();
        m_pc = 8'h00;
        @(negedge clk);
        check_model();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("post_async_pc", 32'(out_pc), 32'd0);
        chk("post_async_valid", 32'(out_valid), 32'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_instr_fetch_queue
